// File: rtl/flash_led_gen.sv
// Multi-mode LED flasher with a step counter shown on a multiplexed 4-digit seven-segment display.
// Define FLASH_LED_GEN_BCD_EN to count steps in BCD (0000..9999) instead of 16-bit binary.
module flash_led_gen #(
    parameter int LED_WIDTH         = 16,
    parameter int CYCLES_PER_SECOND = 100_000_000,
    parameter int SCAN_CYCLES       = 100_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dir,
    input  logic [1:0]           mode,
    input  logic [1:0]           speed,
    input  logic                 pause,
    output logic [LED_WIDTH-1:0] led,
    output logic [3:0]           an,
    output logic [6:0]           seven_segment
);

    localparam int TICK_W = $clog2(CYCLES_PER_SECOND + 1);
    localparam int SCAN_W = $clog2(SCAN_CYCLES + 1);

    typedef enum logic [1:0] {
        MODE_ROTATE = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_FILL   = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_t;

    mode_t                mode_q, mode_nxt;
    logic [TICK_W-1:0]    tick_cnt, tick_term;
    logic                 step;
    logic [LED_WIDTH-1:0] led_nxt;
    logic                 bounce_up, bounce_nxt;
    logic                 fill_q, fill_nxt;
    logic [15:0]          step_cnt, cnt_nxt;
    logic [SCAN_W-1:0]    scan_cnt;
    logic [1:0]           digit;
    logic [3:0]           nibble;
`ifdef FLASH_LED_GEN_BCD_EN
    logic                 carry;
`endif

    // Comparing with >= lets a speed change to a shorter period wrap immediately.
    always_comb begin
        tick_term = TICK_W'((CYCLES_PER_SECOND >> speed) - 1);
        step      = !pause && (tick_cnt >= tick_term);
    end

    always_comb begin
        led_nxt    = led;
        mode_nxt   = mode_q;
        bounce_nxt = bounce_up;
        fill_nxt   = fill_q;
        if (step) begin
            if (mode_t'(mode) != mode_q) begin
                mode_nxt = mode_t'(mode);
                case (mode_t'(mode))
                    MODE_ROTATE: led_nxt = LED_WIDTH'(1);
                    MODE_BOUNCE: begin
                        led_nxt    = LED_WIDTH'(1);
                        bounce_nxt = 1'b1;
                    end
                    MODE_FILL: begin
                        led_nxt  = '0;
                        fill_nxt = 1'b1;
                    end
                    MODE_BLINK:  led_nxt = '1;
                endcase
            end else begin
                case (mode_q)
                    MODE_ROTATE: led_nxt = dir ? {led[0], led[LED_WIDTH-1:1]}
                                               : {led[LED_WIDTH-2:0], led[LED_WIDTH-1]};
                    MODE_BOUNCE: begin
                        if (bounce_up) begin
                            led_nxt = led << 1;
                            if (led[LED_WIDTH-2]) bounce_nxt = 1'b0;
                        end else begin
                            led_nxt = led >> 1;
                            if (led[1]) bounce_nxt = 1'b1;
                        end
                    end
                    MODE_FILL: begin
                        led_nxt = dir ? {fill_q, led[LED_WIDTH-1:1]}
                                      : {led[LED_WIDTH-2:0], fill_q};
                        if (led_nxt == '1)      fill_nxt = 1'b0;
                        else if (led_nxt == '0) fill_nxt = 1'b1;
                    end
                    MODE_BLINK:  led_nxt = ~led;
                endcase
            end
        end
    end

    always_comb begin
        cnt_nxt = step_cnt;
`ifdef FLASH_LED_GEN_BCD_EN
        carry = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            if (carry) begin
                if (step_cnt[4*i +: 4] == 4'd9) begin
                    cnt_nxt[4*i +: 4] = 4'd0;
                end else begin
                    cnt_nxt[4*i +: 4] = step_cnt[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
`else
        cnt_nxt = step_cnt + 16'd1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt  <= '0;
            mode_q    <= MODE_ROTATE;
            led       <= LED_WIDTH'(1);
            bounce_up <= 1'b1;
            fill_q    <= 1'b1;
            step_cnt  <= '0;
        end else begin
            if (!pause) tick_cnt <= step ? '0 : tick_cnt + 1'b1;
            mode_q    <= mode_nxt;
            led       <= led_nxt;
            bounce_up <= bounce_nxt;
            fill_q    <= fill_nxt;
            if (step) step_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        case (digit)
            2'd0:    nibble = step_cnt[3:0];
            2'd1:    nibble = step_cnt[7:4];
            2'd2:    nibble = step_cnt[11:8];
            default: nibble = step_cnt[15:12];
        endcase
    end

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt      <= '0;
            digit         <= '0;
            an            <= 4'b1110;
            seven_segment <= 7'b1000000;
        end else begin
            an            <= ~(4'b0001 << digit);
            seven_segment <= glyph(nibble);
            if (scan_cnt == SCAN_W'(SCAN_CYCLES - 1)) begin
                scan_cnt <= '0;
                digit    <= digit + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
        end
    end

endmodule
